prng_arbiter: RTL and testbench

PRNG_ARBITER -- requirements
Module: prng_arbiter

---
 rtl/prng_pkg.sv | 26 ++
 rtl/prng_arbiter_if.sv | 26 ++
 rtl/prng_xorshift8.sv | 28 ++
 rtl/prng_arbiter.sv | 105 ++++++++++
 tb/tb_prng_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/prng_pkg.sv
// Shared types and constants for the PRNG arbiter: FSM encoding, reset seed
// and the xorshift8 step function.
package prng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEED  = 2'd1,
    ST_GEN   = 2'd2,
    ST_GRANT = 2'd3
  } prng_state_e;

  localparam logic [7:0] RESET_SEED = 8'h01;
  localparam int unsigned SH_A = 3;
  localparam int unsigned SH_B = 5;
  localparam int unsigned SH_C = 4;

  // One xorshift step; every shift is truncated to 8 bits.
  function automatic logic [7:0] xorshift8(input logic [7:0] x);
    logic [7:0] y;
    y = x ^ (x << SH_A);
    y = y ^ (y >> SH_B);
    y = y ^ (y << SH_C);
    return y;
  endfunction

endpackage

// File: rtl/prng_arbiter_if.sv
// Request/grant bus between the requesters and the shared PRNG arbiter.
interface prng_arbiter_if #(
  parameter int NREQ = 4
);
  // Handshake: req_i[n] is a level held high by requester n until it sees
  // gnt_o[n]; gnt_o is a one-cycle one-hot pulse that coincides with
  // data_valid_o and carries the byte on data_o. seed_load_i is a one-cycle
  // strobe qualifying seed_i and needs no acknowledge.
  logic [7:0]      seed_i;
  logic            seed_load_i;
  logic [NREQ-1:0] req_i;
  logic [NREQ-1:0] gnt_o;
  logic [7:0]      data_o;
  logic            data_valid_o;
  logic            busy_o;

  modport master (
    output seed_i, seed_load_i, req_i,
    input  gnt_o, data_o, data_valid_o, busy_o
  );

  modport slave (
    input  seed_i, seed_load_i, req_i,
    output gnt_o, data_o, data_valid_o, busy_o
  );
endinterface

// File: rtl/prng_xorshift8.sv
// 8-bit xorshift state register; load has priority over step and a zero
// seed is replaced so the state can never lock up at zero.
module prng_xorshift8
  import prng_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] state
);

  logic [7:0] state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET_SEED;
    end else if (load) begin
      state_q <= (load_val == 8'h00) ? RESET_SEED : load_val;
    end else if (step) begin
      state_q <= xorshift8(state_q);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/prng_arbiter.sv
// Round-robin arbiter handing out bytes from one shared xorshift PRNG, with
// deferred reseeding when a seed arrives while a grant is in flight.
module prng_arbiter
  import prng_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  prng_arbiter_if.slave  bus,
  output prng_state_e    dbg_state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  prng_state_e     state_q, state_d;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   winner_q, winner_d;
  logic [NREQ-1:0] req_q;
  logic [7:0]      seed_q;
  logic            pending_q;
  logic [7:0]      prng_state;
  logic            prng_step, prng_load;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // A seed, fresh or deferred, always beats a request in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.seed_load_i || pending_q) state_d = ST_SEED;
        else if (|bus.req_i)              state_d = ST_GEN;
      end
      ST_SEED:  state_d = ST_IDLE;
      ST_GEN:   state_d = ST_GRANT;
      ST_GRANT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // First set request at or after ptr, searching cyclically.
  always_comb begin
    logic found;
    winner_d = ptr_q;
    found    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req_q[idx]) begin
        winner_d = PW'(idx);
        found    = 1'b1;
      end
    end
  end

  // req_q snapshots the requests that moved us out of IDLE, so the winner is
  // well defined even if a requester glitches low before GEN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      winner_q  <= '0;
      req_q     <= '0;
      seed_q    <= 8'h00;
      pending_q <= 1'b0;
    end else begin
      if (bus.seed_load_i) seed_q <= bus.seed_i;
      case (state_q)
        ST_IDLE: req_q <= bus.req_i;
        ST_SEED: pending_q <= bus.seed_load_i;
        ST_GEN: begin
          winner_q <= winner_d;
          if (bus.seed_load_i) pending_q <= 1'b1;
        end
        ST_GRANT: begin
          ptr_q <= (winner_q == PW'(NREQ - 1)) ? '0 : winner_q + 1'b1;
          if (bus.seed_load_i) pending_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign prng_step = (state_q == ST_GEN);
  assign prng_load = (state_q == ST_SEED);

  prng_xorshift8 u_prng (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (prng_step),
    .load     (prng_load),
    .load_val (seed_q),
    .state    (prng_state)
  );

  assign bus.gnt_o        = (state_q == ST_GRANT) ? ({{(NREQ-1){1'b0}}, 1'b1} << winner_q) : '0;
  assign bus.data_o       = (state_q == ST_GRANT) ? prng_state : 8'h00;
  assign bus.data_valid_o = (state_q == ST_GRANT);
  assign bus.busy_o       = (state_q != ST_IDLE);
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_prng_arbiter.sv
// Randomised bench for prng_arbiter: a transaction-level model predicts each
// grant (requester, byte, cycle) and a negedge monitor scores what appears.
module tb_prng_arbiter;
  import prng_pkg::*;

  localparam int NREQ = 4;
  localparam int EW   = 32 + NREQ + 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prng_arbiter_if #(.NREQ(NREQ)) bus ();
  prng_state_e dbg_state;

  prng_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset bookkeeping ----------------
  int cyc = 0;
  bit rst_q = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= !rst_n;
  end

  // ---------------- reference model ----------------
  logic [EW-1:0] exp_q[$];
  logic [7:0] m_state = 8'h01;
  int m_ptr = 0;
  int drv_timeouts = 0;
  bit done = 1'b0;

  function automatic logic [7:0] ref_step(input logic [7:0] x);
    int y;
    y = int'(x);
    y = y ^ ((y * 8) % 256);
    y = y ^ (y / 32);
    y = y ^ ((y * 16) % 256);
    return 8'(y);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic full_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_state = 8'h01;
    m_ptr = 0;
  endtask

  task automatic do_seed(input logic [7:0] sv);
    @(negedge clk);
    bus.seed_i = sv;
    bus.seed_load_i = 1'b1;
    @(negedge clk);
    bus.seed_load_i = 1'b0;
    m_state = (sv == 8'h00) ? 8'h01 : sv;
    repeat (2) @(negedge clk);
  endtask

  // Predict every grant of this burst, then raise the requests and serve them.
  task automatic issue(input logic [NREQ-1:0] mask, input int ngr, input bit hold,
                       input bit mid_seed, input logic [7:0] sv);
    logic [NREQ-1:0] rem;
    int p, ec, got, pick;
    @(negedge clk);
    rem = mask;
    p = m_ptr;
    ec = cyc + 2;
    for (int g = 0; g < ngr && rem != '0; g++) begin
      pick = -1;
      for (int k = 0; k < NREQ; k++)
        if (pick < 0 && rem[(p + k) % NREQ]) pick = (p + k) % NREQ;
      m_state = ref_step(m_state);
      exp_q.push_back({32'(ec), NREQ'(1) << pick, m_state});
      if (!hold) rem[pick] = 1'b0;
      p = (pick + 1) % NREQ;
      ec += 3;
    end
    m_ptr = p;
    bus.req_i = mask;
    got = 0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (mid_seed && n == 1) begin
        bus.seed_i = sv;
        bus.seed_load_i = 1'b1;
      end
      if (n == 2) bus.seed_load_i = 1'b0;
      if (bus.gnt_o != '0) got++;
      if (!hold) bus.req_i = bus.req_i & ~bus.gnt_o;
      if (got >= ngr) bus.req_i = '0;
      if (bus.req_i == '0) break;
    end
    if (bus.req_i != '0) begin
      drv_timeouts++;
      bus.req_i = '0;
    end
    bus.seed_load_i = 1'b0;
    if (mid_seed) m_state = (sv == 8'h00) ? 8'h01 : sv;
    repeat (4) @(negedge clk);
  endtask

  // Abort a grant in GEN with a simultaneous seed strobe that must be lost.
  task automatic reset_mid_gen();
    @(negedge clk);
    bus.req_i = 4'b0001;
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_i = '0;
    bus.seed_i = 8'h5A;
    bus.seed_load_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    bus.seed_load_i = 1'b0;
    m_state = 8'h01;
    m_ptr = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [NREQ-1:0] mask;
    logic [7:0] sv;
    int op;
    bus.seed_i = 8'h00;
    bus.seed_load_i = 1'b0;
    bus.req_i = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    issue(4'b0001, 1, 1'b0, 1'b0, 8'h00);          // 0x99
    issue(4'b0001, 1, 1'b0, 1'b0, 8'h00);          // 0x63
    do_seed(8'hA5);
    issue(4'b0010, 1, 1'b0, 1'b0, 8'h00);          // 0x19
    do_seed(8'h00);
    issue(4'b0100, 1, 1'b0, 1'b0, 8'h00);          // 0x99
    full_reset();
    issue(4'b1111, 5, 1'b1, 1'b0, 8'h00);          // 0,1,2,3,0
    reset_mid_gen();
    issue(4'b1111, 4, 1'b0, 1'b0, 8'h00);          // first to requester 0, 0x99
    issue(4'b0001, 1, 1'b0, 1'b1, 8'hA5);          // seed deferred past grant
    issue(4'b0010, 1, 1'b0, 1'b0, 8'h00);          // 0x19

    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 9);
      if (op < 6) begin
        mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        issue(mask, $countones(mask), 1'b0, 1'b0, 8'h00);
      end else if (op < 8) begin
        sv = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        do_seed(sv);
      end else begin
        mask = NREQ'(1) << $urandom_range(0, NREQ - 1);
        issue(mask, 1, 1'b0, 1'b1, 8'($urandom_range(0, 255)));
      end
    end
    repeat (3) @(negedge clk);
    done = 1'b1;
  end

  // ---------------- scoreboard / monitor ----------------
  int n_cmp = 0;
  int n_fail = 0;
  bit finished = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (cyc > 0 && !finished) begin
      if (rst_q) begin
        check("reset_outputs", {bus.gnt_o, bus.data_o, bus.data_valid_o, bus.busy_o, dbg_state},
              {{NREQ{1'b0}}, 8'h00, 1'b0, 1'b0, ST_IDLE});
      end else if (bus.data_valid_o) begin
        check("grant_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("grant_onehot", 64'(bus.gnt_o), 64'(e[8 +: NREQ]));
          check("grant_data", 64'(bus.data_o), 64'(e[7:0]));
          check("grant_cycle", 64'(cyc), 64'(e[EW-1 -: 32]));
          check("grant_busy", 64'(bus.busy_o), 64'd1);
        end
      end else begin
        check("idle_outputs", {bus.gnt_o, bus.data_o}, '0);
      end
      if (done) begin
        finished = 1'b1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("driver_timeouts", 64'(drv_timeouts), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
      end
    end
  end

  // Hard stop in case the driver never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
